divider_scheduler: RTL and testbench

Shares one pipelined `array_divider` among `NUM_REQ` requesters. Each requester gets a valid/ready request port and a response port; the scheduler grants round-robin and issues at most one division per cycle through an issue register. It tags every in-flight operation and routes `Q`/`R` back to the originator. It sits between the requesting datapath blocks and the single shared divider instance.

---
 rtl/divider_sched_pkg.sv | 28 ++
 rtl/divider_scheduler_rr_arbiter.sv | 56 +++++
 rtl/divider_scheduler.sv | 169 ++++++++++++++++
 tb/tb_divider_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_sched_pkg.sv
// divider_sched_pkg
// Shared types and constants for the divider scheduler.
//   ID_W        : requester-id width for the default build (minimum 1)
//   OPW         : operand width, DATAWIDTH + FRAC_BITS, for the default build
//   ID_MAX_W    : tag id field width; covers up to 16 requesters
//   sched_tag_t : {valid, id, dbz} entry that travels beside the divider pipe
package divider_sched_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATAWIDTH_DEF = 18;
  localparam int FRAC_BITS_DEF = 8;
  localparam int ID_MAX_W      = 4;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = id_width(NUM_REQ_DEF);
  localparam int OPW  = DATAWIDTH_DEF + FRAC_BITS_DEF;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic                dbz;
  } sched_tag_t;

endpackage

// File: rtl/divider_scheduler_rr_arbiter.sv
// rr_arbiter
// Rotating-priority round-robin arbiter. The search starts at the pointer and
// wraps; after a grant the pointer moves to the slot just past the winner.
//   clk, rst : clock, asynchronous active-high reset (pointer returns to 0)
//   req      : N request lines
//   en       : when low no grant is produced (combinational)
//   grant    : one-hot grant, combinational
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N <= 1) ? 1 : $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_hit;
  logic [N-1:0]  w_grant;

  // First requesting slot at or after the pointer, wrapping modulo N.
  always_comb begin
    w_grant = {N{1'b0}};
    w_idx   = {PW{1'b0}};
    w_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % N;
      if (en && !w_hit && req[idx]) begin
        w_grant[idx] = 1'b1;
        w_idx        = PW'(idx);
        w_hit        = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  assign grant = w_grant;

  // Pointer advances past the winner on every handshake, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= {PW{1'b0}};
    end else if (w_hit) begin
      r_ptr <= (w_idx == PW'(N - 1)) ? {PW{1'b0}} : (w_idx + PW'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/divider_scheduler.sv
// divider_scheduler
// Shares one pipelined divider among NUM_REQ requesters. Grants round-robin,
// registers one operation per cycle into the divider, carries a tag beside the
// divider pipe and steers the quotient/remainder back to the originator.
//   clk, rst                 : clock, asynchronous active-high reset
//   en                       : gate for new grants; in-flight work still drains
//   req_valid/req_a/req_b    : per-requester request and operands
//   req_ready                : one-hot grant, combinational
//   div_i_valid/div_a/div_b  : issue register towards the divider
//   div_o_valid/div_q/div_r  : divider result
//   resp_valid/resp_q/resp_r : one-hot response strobe and shared data
//   resp_dbz                 : divide-by-zero flag of the response
//   busy                     : any operation in the issue register or tag pipe
//   err_sync                 : sticky tag/divider valid mismatch
module divider_scheduler
  import divider_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATAWIDTH   = 18,
  parameter int FRAC_BITS   = 8,
  parameter int DIV_LATENCY = 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0][DATAWIDTH+FRAC_BITS-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DATAWIDTH+FRAC_BITS-1:0]   req_b,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic                                          div_i_valid,
  output logic [DATAWIDTH+FRAC_BITS-1:0]                div_a,
  output logic [DATAWIDTH+FRAC_BITS-1:0]                div_b,
  input  logic                                          div_o_valid,
  input  logic [DATAWIDTH-1:0]                          div_q,
  input  logic [DATAWIDTH-1:0]                          div_r,
  output logic [NUM_REQ-1:0]                            resp_valid,
  output logic [DATAWIDTH-1:0]                          resp_q,
  output logic [DATAWIDTH-1:0]                          resp_r,
  output logic                                          resp_dbz,
  output logic                                          busy,
  output logic                                          err_sync
);

  localparam int OW = DATAWIDTH + FRAC_BITS;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_hs;
  logic [ID_MAX_W-1:0] w_gid;
  logic [OW-1:0]       w_sel_a;
  logic [OW-1:0]       w_sel_b;

  logic                r_iss_valid;
  logic [ID_MAX_W-1:0] r_iss_id;
  logic                r_iss_dbz;
  logic [OW-1:0]       r_div_a;
  logic [OW-1:0]       r_div_b;

  sched_tag_t          r_tag [DIV_LATENCY];
  sched_tag_t          w_tail;
  logic                w_hit;
  logic                w_tag_busy;
  logic                r_err_sync;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (en),
    .grant (w_grant)
  );

  // The arbiter only grants requesting slots, so any grant is a handshake.
  assign req_ready = w_grant;
  assign w_hs      = |w_grant;

  // One-hot grant to index and AND-OR operand select.
  always_comb begin
    w_gid   = {ID_MAX_W{1'b0}};
    w_sel_a = {OW{1'b0}};
    w_sel_b = {OW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gid   = w_gid   | (w_grant[i] ? ID_MAX_W'(i) : {ID_MAX_W{1'b0}});
      w_sel_a = w_sel_a | (req_a[i] & {OW{w_grant[i]}});
      w_sel_b = w_sel_b | (req_b[i] & {OW{w_grant[i]}});
    end
  end

  // Issue register: operands hold their last value when nothing is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_id    <= {ID_MAX_W{1'b0}};
      r_iss_dbz   <= 1'b0;
      r_div_a     <= {OW{1'b0}};
      r_div_b     <= {OW{1'b0}};
    end else begin
      r_iss_valid <= w_hs;
      if (w_hs) begin
        r_iss_id  <= w_gid;
        r_iss_dbz <= (w_sel_b == {OW{1'b0}});
        r_div_a   <= w_sel_a;
        r_div_b   <= w_sel_b;
      end else begin
        r_iss_id  <= r_iss_id;
        r_iss_dbz <= r_iss_dbz;
        r_div_a   <= r_div_a;
        r_div_b   <= r_div_b;
      end
    end
  end

  assign div_i_valid = r_iss_valid;
  assign div_a       = r_div_a;
  assign div_b       = r_div_b;

  // Tag pipe shifts every cycle so it stays aligned with the divider stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DIV_LATENCY; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= {r_iss_valid, r_iss_id, r_iss_dbz};
      for (int k = 1; k < DIV_LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Response steering; a valid mismatch between tag and divider yields no strobe.
  always_comb begin
    w_tail     = r_tag[DIV_LATENCY-1];
    w_hit      = w_tail.valid & div_o_valid;
    resp_valid = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = w_hit & (w_tail.id == ID_MAX_W'(i));
    end
    if (w_tail.dbz) begin
      resp_q = {DATAWIDTH{1'b1}};
      resp_r = {DATAWIDTH{1'b0}};
    end else begin
      resp_q = div_q;
      resp_r = div_r;
    end
    resp_dbz = w_hit & w_tail.dbz;
  end

  // Any valid tag in the pipe keeps busy asserted.
  always_comb begin
    w_tag_busy = 1'b0;
    for (int k = 0; k < DIV_LATENCY; k++) begin
      w_tag_busy = w_tag_busy | r_tag[k].valid;
    end
  end

  assign busy = r_iss_valid | w_tag_busy;

  // Sticky sync error: tag and divider disagree on result validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sync <= 1'b0;
    end else begin
      r_err_sync <= r_err_sync | (w_tail.valid ^ div_o_valid);
    end
  end

  assign err_sync = r_err_sync;

endmodule

// File: tb/tb_divider_scheduler.sv
// tb_divider_scheduler
// Bench for divider_scheduler with a behavioural divider stand-in, a queue-based
// reference model checked every cycle, and literal checks for directed cases.
module tb_divider_scheduler;

  localparam int NR  = 4;
  localparam int DW  = 18;
  localparam int FB  = 8;
  localparam int LAT = 1;
  localparam int OW  = DW + FB;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][OW-1:0]  req_a;
  logic [NR-1:0][OW-1:0]  req_b;
  logic [NR-1:0]          req_ready;
  logic                   div_i_valid;
  logic [OW-1:0]          div_a;
  logic [OW-1:0]          div_b;
  logic                   div_o_valid;
  logic [DW-1:0]          div_q;
  logic [DW-1:0]          div_r;
  logic [NR-1:0]          resp_valid;
  logic [DW-1:0]          resp_q;
  logic [DW-1:0]          resp_r;
  logic                   resp_dbz;
  logic                   busy;
  logic                   err_sync;
  logic                   force_ov;

  int n_checks = 0;
  int n_err    = 0;

  divider_scheduler #(
    .NUM_REQ(NR), .DATAWIDTH(DW), .FRAC_BITS(FB), .DIV_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .div_i_valid(div_i_valid), .div_a(div_a), .div_b(div_b),
    .div_o_valid(div_o_valid), .div_q(div_q), .div_r(div_r),
    .resp_valid(resp_valid), .resp_q(resp_q), .resp_r(resp_r),
    .resp_dbz(resp_dbz), .busy(busy), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  // Fixed-point division as the real divider computes it; garbage on b==0.
  function automatic logic [DW-1:0] fx_q(input logic [OW-1:0] a, input logic [OW-1:0] b);
    longint unsigned num;
    if (b == '0) return 18'h2AAAA;
    num = longint'(a) << FB;
    return DW'(num / longint'(b));
  endfunction

  function automatic logic [DW-1:0] fx_r(input logic [OW-1:0] a, input logic [OW-1:0] b);
    longint unsigned num;
    if (b == '0) return 18'h15555;
    num = longint'(a) << FB;
    return DW'(num % longint'(b));
  endfunction

  // Divider stand-in: LAT registered stages, sharing rst with the scheduler.
  logic          sv [LAT];
  logic [DW-1:0] sq [LAT];
  logic [DW-1:0] sr [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin sv[k] <= 1'b0; sq[k] <= '0; sr[k] <= '0; end
    end else begin
      sv[0] <= div_i_valid;
      sq[0] <= fx_q(div_a, div_b);
      sr[0] <= fx_r(div_a, div_b);
      for (int k = 1; k < LAT; k++) begin sv[k] <= sv[k-1]; sq[k] <= sq[k-1]; sr[k] <= sr[k-1]; end
    end
  end
  assign div_o_valid = sv[LAT-1] | force_ov;
  assign div_q       = sq[LAT-1];
  assign div_r       = sr[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted operations queued with the cycle they must return.
  typedef struct {
    int            due;
    int            id;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
  } ent_t;

  ent_t mq[$];
  int   m_ptr   = 0;
  logic err_exp = 1'b0;
  int   cyc     = 0;

  task automatic model_clear();
    mq.delete();
    m_ptr   = 0;
    err_exp = 1'b0;
  endtask

  // Per-cycle compare, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    logic          tail;
    logic [NR-1:0] eg;
    ent_t          e;
    cyc++;
    chk("busy", 64'(busy), 64'(mq.size() != 0));
    chk("err_sync", 64'(err_sync), 64'(err_exp));
    tail = (mq.size() != 0) && (mq[0].due == cyc);
    if (force_ov && !tail) err_exp = 1'b1;
    if (tail) begin
      e = mq.pop_front();
      chk("resp_valid", 64'(resp_valid), 64'(4'b0001 << e.id));
      if (e.b == '0) begin
        chk("resp_q_dbz", 64'(resp_q), 64'({DW{1'b1}}));
        chk("resp_r_dbz", 64'(resp_r), 64'd0);
        chk("resp_dbz", 64'(resp_dbz), 64'd1);
      end else begin
        chk("resp_q", 64'(resp_q), 64'(fx_q(e.a, e.b)));
        chk("resp_r", 64'(resp_r), 64'(fx_r(e.a, e.b)));
        chk("resp_dbz", 64'(resp_dbz), 64'd0);
      end
    end else begin
      chk("resp_idle", 64'(resp_valid), 64'd0);
      chk("resp_dbz_idle", 64'(resp_dbz), 64'd0);
    end
    eg = '0;
    if (en) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (eg == '0 && req_valid[idx]) begin
          eg = NR'(1) << idx;
          e.due = cyc + 1 + LAT;
          e.id  = idx;
          e.a   = req_a[idx];
          e.b   = req_b[idx];
          mq.push_back(e);
          m_ptr = (idx + 1) % NR;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(eg));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; force_ov = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_div_i_valid", 64'(div_i_valid), 64'd0);
    chk("rst_div_a", 64'(div_a), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_sync), 64'd0);
    rst = 1'b0;

    // Single request from requester 2: 0x100 / 0x200 = 0.5 -> 0x80.
    tick();
    en = 1'b1;
    req_valid = 4'b0100; req_a[2] = 26'h100; req_b[2] = 26'h200;
    #2 chk("single_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    tick();
    #2;
    chk("single_resp_valid", 64'(resp_valid), 64'h4);
    chk("single_resp_q", 64'(resp_q), 64'h80);
    chk("single_resp_r", 64'(resp_r), 64'h0);

    // All four requesters from reset: strict 0,1,2,3 rotation.
    rst = 1'b1; model_clear();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_a[i] = OW'(32'h300 * (i + 1));
      req_b[i] = OW'(32'h100 + i);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #2 chk("rr_order", 64'(req_ready), 64'(4'b0001 << (k % NR)));
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Divide by zero from requester 1.
    req_valid = 4'b0010; req_a[1] = 26'h1234; req_b[1] = 26'h0;
    tick();
    req_valid = '0;
    tick();
    #2;
    chk("dbz_valid", 64'(resp_valid), 64'h2);
    chk("dbz_q", 64'(resp_q), 64'h3FFFF);
    chk("dbz_r", 64'(resp_r), 64'h0);
    chk("dbz_flag", 64'(resp_dbz), 64'h1);
    repeat (2) tick();

    // en dropped with two operations in flight.
    req_b[1] = 26'h77;
    req_valid = 4'b0011;
    tick();
    tick();
    en = 1'b0;
    #2 chk("en_off_ready", 64'(req_ready), 64'h0);
    chk("en_off_busy0", 64'(busy), 64'h1);
    tick();
    #2 chk("en_off_busy1", 64'(busy), 64'h1);
    tick();
    #2 chk("en_off_busy2", 64'(busy), 64'h0);
    req_valid = '0; en = 1'b1;
    tick();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 7) != 0);
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_a[i] = OW'($urandom);
        req_b[i] = ($urandom_range(0, 5) == 0) ? '0 : OW'($urandom_range(1, 32'h3FFFFFF));
      end
      tick();
    end
    req_valid = '0; en = 1'b1;
    repeat (4) tick();

    // Asynchronous reset mid-cycle with operations in flight.
    req_valid = 4'hF;
    repeat (3) tick();
    req_valid = '0;
    #1 rst = 1'b1;
    model_clear();
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_div_i_valid", 64'(div_i_valid), 64'h0);
    chk("arst_div_b", 64'(div_b), 64'h0);
    rst = 1'b0;
    repeat (4) tick();

    // Divider claims a result with an empty tag pipe.
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    #2 chk("sync_err_set", 64'(err_sync), 64'h1);
    chk("sync_no_resp", 64'(resp_valid), 64'h0);
    repeat (3) tick();
    #2 chk("sync_err_sticky", 64'(err_sync), 64'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
